// File: rtl/memory_pipe.sv
// memory_pipe: scratch RAM with auto-clear after reset, range checks,
// optional write-to-read bypass and a 1- or 2-stage read pipeline.
module memory_pipe #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 7,
  parameter int RD_LAT = 1,
  parameter int BYPASS = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              write,
  input  logic              read,
  input  logic [ADDR_W-1:0] addr_w,
  input  logic [ADDR_W-1:0] addr_r,
  input  logic [DATA_W-1:0] datain,
  output logic [DATA_W-1:0] dataout,
  output logic              rvalid,
  output logic              busy,
  output logic              err_w,
  output logic              err_r
);

  localparam int PTR_W = ADDR_W + 1;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [PTR_W-1:0]  clr_ptr;
  logic [PTR_W-1:0]  clr_ptr_n;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;

  logic              run;
  logic              w_ok;
  logic              r_ok;
  logic              rd_fire;
  logic              rd_hit;
  logic [DATA_W-1:0] rd_word;

  logic [RD_LAT-1:0] pv;
  logic [RD_LAT-1:0] pe;
  logic [DATA_W-1:0] pd [RD_LAT];

  // Widened compare so DEPTH == 2**ADDR_W is handled without overflow
  assign w_ok    = {1'b0, addr_w} < PTR_W'(DEPTH);
  assign r_ok    = {1'b0, addr_r} < PTR_W'(DEPTH);
  assign rd_fire = run && read;
  assign rd_hit  = write && w_ok && (addr_w == addr_r);
  assign busy    = reset || (state == CLEAR);

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_n;
      clr_ptr <= clr_ptr_n;
    end
  end

  always_comb begin
    state_n   = state;
    clr_ptr_n = clr_ptr;
    mem_we    = 1'b0;
    mem_wa    = '0;
    mem_wd    = '0;
    run       = 1'b0;
    case (state)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_wa    = clr_ptr[ADDR_W-1:0];
        clr_ptr_n = clr_ptr + PTR_W'(1);
        if (clr_ptr == PTR_W'(DEPTH - 1)) begin
          state_n = RUN;
        end
      end
      RUN: begin
        run = 1'b1;
        if (write && w_ok) begin
          mem_we = 1'b1;
          mem_wa = addr_w;
          mem_wd = datain;
        end
      end
      default: state_n = CLEAR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (mem_we && !reset) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  // mem is read before this edge's write lands, so the old word is seen
  always_comb begin
    rd_word = '0;
    if (r_ok) begin
      if ((BYPASS != 0) && rd_hit) begin
        rd_word = datain;
      end else begin
        rd_word = mem[addr_r];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pv      <= '0;
      pe      <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pd[i] <= '0;
      end
      dataout <= '0;
      rvalid  <= 1'b0;
      err_r   <= 1'b0;
      err_w   <= 1'b0;
    end else begin
      pv[0] <= rd_fire;
      pe[0] <= rd_fire && !r_ok;
      pd[0] <= rd_word;
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        pe[i] <= pe[i-1];
        pd[i] <= pd[i-1];
      end
      rvalid <= pv[RD_LAT-1];
      err_r  <= pv[RD_LAT-1] && pe[RD_LAT-1];
      if (pv[RD_LAT-1]) begin
        dataout <= pd[RD_LAT-1];
      end
      err_w <= run && write && !w_ok;
    end
  end

endmodule

// File: tb/tb_memory_pipe.sv
// tb_memory_pipe: two memory_pipe configurations driven by one stimulus
// stream, checked by a scoreboard fed from an array-based memory model.
module tb_memory_pipe;

  localparam int DEPTH = 7;

  logic       clock;
  logic       reset;
  logic       write;
  logic       read;
  logic [2:0] addr_w;
  logic [2:0] addr_r;
  logic [7:0] datain;

  logic [7:0] dataout1, dataout2;
  logic       rvalid1, rvalid2;
  logic       busy1, busy2;
  logic       err_w1, err_w2;
  logic       err_r1, err_r2;

  memory_pipe #(
    .DATA_W(8), .ADDR_W(3), .DEPTH(DEPTH), .RD_LAT(1), .BYPASS(1)
  ) dut1 (
    .clock(clock), .reset(reset), .write(write), .read(read),
    .addr_w(addr_w), .addr_r(addr_r), .datain(datain),
    .dataout(dataout1), .rvalid(rvalid1), .busy(busy1),
    .err_w(err_w1), .err_r(err_r1)
  );

  memory_pipe #(
    .DATA_W(8), .ADDR_W(3), .DEPTH(DEPTH), .RD_LAT(2), .BYPASS(0)
  ) dut2 (
    .clock(clock), .reset(reset), .write(write), .read(read),
    .addr_w(addr_w), .addr_r(addr_r), .datain(datain),
    .dataout(dataout2), .rvalid(rvalid2), .busy(busy2),
    .err_w(err_w2), .err_r(err_r2)
  );

  typedef struct {
    int         due;
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t       q1[$];
  exp_t       q2[$];
  logic [7:0] mdl [8];
  int         clr_left;
  int         cyc;
  bit         live;
  bit         exp_errw;
  logic [7:0] hold1, hold2;
  int         checks;
  int         errors;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // One clock: drive inputs, then apply the edge's effect to the model
  task automatic drive(bit rst, bit w, bit r, int aw, int ar,
                       logic [7:0] d);
    exp_t e1, e2;
    @(negedge clock);
    #1;
    reset  = rst;
    write  = w;
    read   = r;
    addr_w = aw[2:0];
    addr_r = ar[2:0];
    datain = d;
    @(posedge clock);
    cyc++;
    if (rst) begin
      live     = 1'b1;
      clr_left = DEPTH;
      q1.delete();
      q2.delete();
      hold1    = 8'h00;
      hold2    = 8'h00;
      exp_errw = 1'b0;
    end else if (clr_left > 0) begin
      mdl[DEPTH-clr_left] = 8'h00;
      clr_left--;
      exp_errw = 1'b0;
    end else begin
      if (r) begin
        e1.err  = (ar >= DEPTH);
        e2.err  = e1.err;
        e1.due  = cyc + 1;
        e2.due  = cyc + 2;
        e1.data = e1.err ? 8'h00 : ((w && aw == ar) ? d : mdl[ar]);
        e2.data = e2.err ? 8'h00 : mdl[ar];
        q1.push_back(e1);
        q2.push_back(e2);
      end
      exp_errw = w && (aw >= DEPTH);
      if (w && aw < DEPTH) mdl[aw] = d;
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 8'h00);
  endtask

  always @(negedge clock) begin
    if (live) begin
      chk("busy1", busy1, clr_left > 0);
      chk("busy2", busy2, clr_left > 0);
      chk("err_w1", err_w1, exp_errw);
      chk("err_w2", err_w2, exp_errw);
      if (q1.size() > 0 && q1[0].due == cyc) begin
        chk("rvalid1", rvalid1, 1);
        chk("dataout1", dataout1, q1[0].data);
        chk("err_r1", err_r1, q1[0].err);
        hold1 = q1[0].data;
        void'(q1.pop_front());
      end else begin
        chk("rvalid1_idle", rvalid1, 0);
        chk("err_r1_idle", err_r1, 0);
        chk("hold1", dataout1, hold1);
      end
      if (q2.size() > 0 && q2[0].due == cyc) begin
        chk("rvalid2", rvalid2, 1);
        chk("dataout2", dataout2, q2[0].data);
        chk("err_r2", err_r2, q2[0].err);
        hold2 = q2[0].data;
        void'(q2.pop_front());
      end else begin
        chk("rvalid2_idle", rvalid2, 0);
        chk("err_r2_idle", err_r2, 0);
        chk("hold2", dataout2, hold2);
      end
    end
  end

  initial begin
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    live     = 1'b0;
    clr_left = 0;
    exp_errw = 1'b0;
    hold1    = 8'h00;
    hold2    = 8'h00;
    reset    = 1'b1;
    write    = 1'b0;
    read     = 1'b0;
    addr_w   = 3'd0;
    addr_r   = 3'd0;
    datain   = 8'h00;

    // Reset, then a write and a read during CLEAR that must be ignored
    drive(1, 0, 0, 0, 0, 8'h00);
    drive(1, 0, 0, 0, 0, 8'h00);
    drive(0, 1, 0, 2, 0, 8'hAA);
    drive(0, 0, 1, 0, 2, 8'h00);
    idle(DEPTH);
    drive(0, 0, 1, 0, 2, 8'h00);
    idle(3);

    // Write then read, then hold
    drive(0, 1, 0, 5, 0, 8'h05);
    drive(0, 0, 1, 0, 5, 8'h00);
    idle(4);

    // Same-cycle write/read of one address
    drive(0, 1, 1, 5, 5, 8'h08);
    idle(3);
    drive(0, 0, 1, 0, 5, 8'h00);
    idle(3);

    // Out-of-range write and read, then sweep the valid words
    drive(0, 1, 0, 7, 0, 8'h04);
    drive(0, 0, 1, 0, 7, 8'h00);
    drive(0, 1, 1, 7, 7, 8'h33);
    for (int a = 0; a < DEPTH; a++) drive(0, 0, 1, 0, a, 8'h00);
    idle(3);

    // Back-to-back reads
    drive(0, 1, 0, 1, 0, 8'h70);
    drive(0, 1, 0, 2, 0, 8'h04);
    drive(0, 1, 0, 3, 0, 8'h40);
    drive(0, 0, 1, 0, 1, 8'h00);
    drive(0, 0, 1, 0, 2, 8'h00);
    drive(0, 0, 1, 0, 3, 8'h00);
    idle(3);

    // Reset one cycle after a read: the read must vanish
    drive(0, 0, 1, 0, 1, 8'h00);
    drive(1, 0, 0, 0, 0, 8'h00);
    idle(DEPTH + 1);
    for (int a = 0; a < 8; a++) drive(0, 0, 1, 0, a, 8'h00);
    idle(3);

    // Randomised traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 79) == 0), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 7),
            $urandom_range(0, 7), 8'($urandom));
    end
    idle(4);
    @(negedge clock);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
